// File: rtl/hamming_min_search.sv
// Minimum-distance search over a stream of K hamming distances.
// Reports the first index reaching the minimum plus a threshold match.
module hamming_min_search #(
  parameter int N          = 8,
  parameter int K          = 16,
  parameter int EARLY_EXIT = 0,
  localparam int W  = $clog2(N + 1),
  localparam int KM = (K - 1 > 1) ? (K - 1) : 1,
  localparam int IW = $clog2(KM + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          d_valid,
  output logic          d_ready,
  input  logic [W-1:0]  d,
  input  logic [W-1:0]  thresh,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  min_d,
  output logic [IW-1:0] min_idx,
  output logic          match
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(K - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  min_q, min_d_n;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  thr_q, thr_d;
  logic          match_q, match_d;
  logic          busy_q, done_q;
  logic          last_beat;

  always_comb begin
    state_d   = state_q;
    min_d_n   = min_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    thr_d     = thr_q;
    match_d   = match_q;
    last_beat = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          min_d_n = '1;
          idx_d   = '0;
          cnt_d   = '0;
          match_d = 1'b0;
          thr_d   = thresh;
        end
      end
      SCAN: begin
        if (d_valid) begin
          if (d < min_q) begin
            min_d_n = d;
            idx_d   = cnt_q;
          end
          cnt_d = cnt_q + IW'(1);
          // a zero distance cannot be beaten, so optionally stop early
          last_beat = (cnt_q == LAST) ||
                      ((EARLY_EXIT != 0) && (d == '0));
          if (last_beat) begin
            state_d = DONE;
            match_d = (min_d_n <= thr_q);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      min_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      thr_q   <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d_n;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      match_q <= match_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign d_ready = (state_q == SCAN);
  assign busy    = busy_q;
  assign done    = done_q;
  assign min_d   = min_q;
  assign min_idx = idx_q;
  assign match   = match_q;

endmodule

// File: tb/tb_hamming_min_search.sv
// Scoreboard bench: two K=4 searchers (plain and early-exit) share
// one randomized stimulus stream; a negedge monitor checks both.
module tb_hamming_min_search;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic d_valid;
  logic [3:0] d;
  logic [3:0] thresh;

  logic [1:0]      dr, bz, dn, mt;
  logic [1:0][3:0] md;
  logic [1:0][1:0] mi;

  always #5 clk = ~clk;

  hamming_min_search #(.N(8), .K(4), .EARLY_EXIT(0)) u_plain (
    .clk(clk), .rst(rst), .start(start), .d_valid(d_valid),
    .d_ready(dr[0]), .d(d), .thresh(thresh), .busy(bz[0]),
    .done(dn[0]), .min_d(md[0]), .min_idx(mi[0]), .match(mt[0])
  );

  hamming_min_search #(.N(8), .K(4), .EARLY_EXIT(1)) u_early (
    .clk(clk), .rst(rst), .start(start), .d_valid(d_valid),
    .d_ready(dr[1]), .d(d), .thresh(thresh), .busy(bz[1]),
    .done(dn[1]), .min_d(md[1]), .min_idx(mi[1]), .match(mt[1])
  );

  typedef struct {
    int md;
    int mi;
    int mt;
    int nb;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input int j,
                     input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL dut%0d %s: got %0d expected %0d", j, nm, act, exp);
    end
  endtask

  // Reference: minimum over the consumed prefix, first index wins.
  function automatic exp_t model(input int b[4], input int thr,
                                 input bit ee);
    exp_t e;
    int n;
    n = 4;
    if (ee)
      for (int i = 3; i >= 0; i--)
        if (b[i] == 0) n = i + 1;
    e.md = 15;
    e.mi = 0;
    for (int i = 0; i < n; i++)
      if (b[i] < e.md) begin
        e.md = b[i];
        e.mi = i;
      end
    e.mt = (e.md <= thr) ? 1 : 0;
    e.nb = n;
    return e;
  endfunction

  function automatic int qsize(input int j);
    return (j == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int front_nb(input int j);
    if (qsize(j) == 0) return 99;
    return (j == 0) ? q0[0].nb : q1[0].nb;
  endfunction

  bit scan[2], dexp[2], first[2];
  int cnt[2], lmd[2], lmi[2], lmt[2];

  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (!rst) begin
        chk("rst_d_ready", j, int'(dr[j]), 0);
        chk("rst_busy", j, int'(bz[j]), 0);
        chk("rst_done", j, int'(dn[j]), 0);
        chk("rst_min_d", j, int'(md[j]), 0);
        chk("rst_min_idx", j, int'(mi[j]), 0);
        chk("rst_match", j, int'(mt[j]), 0);
        scan[j] = 0; dexp[j] = 0; first[j] = 0; cnt[j] = 0;
        lmd[j] = 0; lmi[j] = 0; lmt[j] = 0;
        if (j == 0) q0.delete(); else q1.delete();
      end else begin
        bit nd, nf;
        chk("d_ready", j, int'(dr[j]), int'(scan[j]));
        chk("done", j, int'(dn[j]), int'(dexp[j]));
        if (first[j]) begin
          chk("scan_init_min_d", j, int'(md[j]), 15);
          chk("scan_init_idx", j, int'(mi[j]), 0);
          chk("scan_init_match", j, int'(mt[j]), 0);
        end
        if (dn[j]) begin
          if (qsize(j) == 0) chk("q_underflow", j, 1, 0);
          else begin
            exp_t e;
            if (j == 0) e = q0.pop_front(); else e = q1.pop_front();
            chk("min_d", j, int'(md[j]), e.md);
            chk("min_idx", j, int'(mi[j]), e.mi);
            chk("match", j, int'(mt[j]), e.mt);
            chk("busy_done", j, int'(bz[j]), 1);
            lmd[j] = e.md; lmi[j] = e.mi; lmt[j] = e.mt;
          end
        end else if (!scan[j] && !dexp[j]) begin
          chk("idle_busy", j, int'(bz[j]), 0);
          chk("hold_min_d", j, int'(md[j]), lmd[j]);
          chk("hold_idx", j, int'(mi[j]), lmi[j]);
          chk("hold_match", j, int'(mt[j]), lmt[j]);
        end
        nd = 0;
        nf = 0;
        if (scan[j] && d_valid) begin
          cnt[j]++;
          if (cnt[j] == front_nb(j)) begin
            scan[j] = 0;
            nd = 1;
          end
        end else if (!scan[j] && !dexp[j] && start) begin
          scan[j] = 1;
          cnt[j] = 0;
          nf = 1;
        end
        dexp[j] = nd;
        first[j] = nf;
      end
    end
  end

  task automatic search(input int b[4], input int thr,
                        input int gmax, input bit smid);
    q0.push_back(model(b, thr, 1'b0));
    q1.push_back(model(b, thr, 1'b1));
    start = 1'b1;
    thresh = 4'(thr);
    @(posedge clk); #1;
    start = 1'b0;
    thresh = 4'($urandom_range(0, 15));
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, gmax)) begin
        d_valid = 1'b0;
        d = 4'($urandom);
        @(posedge clk); #1;
      end
      d_valid = 1'b1;
      d = 4'(b[i]);
      start = smid && (i == 1);
      @(posedge clk); #1;
      d_valid = 1'b0;
      start = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic abort_after_two(input int b[4]);
    q0.push_back(model(b, 5, 1'b0));
    q1.push_back(model(b, 5, 1'b1));
    start = 1'b1;
    thresh = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d_valid = 1'b1;
      d = 4'(b[i]);
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    d_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int b[4];
    rst = 1'b0;
    start = 1'b1;
    d_valid = 1'b1;
    d = 4'd5;
    thresh = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    d_valid = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    b = '{5, 3, 7, 3}; search(b, 3, 0, 1'b0);
    b = '{8, 8, 8, 8}; search(b, 2, 0, 1'b0);
    b = '{2, 9, 9, 9}; search(b, 2, 0, 1'b0);
    b = '{6, 1, 4, 2}; search(b, 4, 3, 1'b0);
    b = '{4, 0, 5, 6}; search(b, 0, 0, 1'b0);
    b = '{15, 15, 15, 15}; search(b, 15, 1, 1'b0);
    b = '{9, 7, 3, 5}; search(b, 6, 1, 1'b1);
    b = '{7, 5, 1, 2}; abort_after_two(b);
    b = '{3, 12, 0, 1}; search(b, 1, 2, 1'b0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++)
        b[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
      search(b, $urandom_range(0, 15), 2,
             (b[0] != 0) && ($urandom_range(0, 1) == 1));
    end

    chk("q_empty", 0, q0.size(), 0);
    chk("q_empty", 1, q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/hamming_min_search.md
Name: hamming_min_search

Overview:
- Downstream consumer of the hamming-distance stage. Takes a stream of K distance results, one per database candidate against a single query.
- Tracks the minimum distance and the index of the candidate that produced it.
- On completion, reports a thresholded match flag for the identification and matching netlists.

Parameters:
- N, 8: bit-width of the compared vectors. Distance port width is W = number of bits needed to represent N (W=4 for N=8), using the same log2 helper as the distance stage.
- K, 16: number of candidates per search. K >= 1. Index width IW = bits needed to represent max(K-1,1).
- EARLY_EXIT, 0: when 1, the search terminates on the first accepted distance equal to 0.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin a new search. Sampled only in IDLE.
- d_valid, input, 1: distance beat valid.
- d_ready, output, 1: block can accept a beat.
- d, input, W: distance value, unsigned.
- thresh, input, W: match threshold, unsigned. Sampled on the cycle `start` is accepted.
- busy, output, 1: high in SCAN and DONE.
- done, output, 1: one-cycle pulse when the result is valid.
- min_d, output, W: running or final minimum distance.
- min_idx, output, IW: index of the first candidate achieving `min_d`.
- match, output, 1: `min_d <= thresh`. Valid from `done` onward.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - `d_ready`, `busy`, `done`, `match` = 0; `min_d`, `min_idx` = 0; candidate counter = 0; stored threshold = 0.
  - Reset in any state aborts the search; no `done` is generated.
- States: IDLE, SCAN, DONE. All outputs are registered except `d_ready`, which equals (state==SCAN).
- IDLE:
  - `start`=1 -> SCAN next cycle.
  - On that edge: `min_d` <= all-ones (2^W-1), `min_idx` <= 0, counter <= 0, `match` <= 0, store `thresh`.
  - `start`=0 -> stay in IDLE; previous results hold.
- SCAN:
  - A beat is accepted when `d_valid` & `d_ready`.
  - On acceptance: if `d` < `min_d` (strictly less), `min_d` <= `d` and `min_idx` <= counter. Ties keep the earlier index.
  - Counter increments on every accepted beat. Cycles with `d_valid`=0 change nothing.
  - Accepting the beat with counter==K-1 -> DONE.
  - EARLY_EXIT=1 and accepted `d`==0 -> DONE immediately, with `min_idx` = that counter. Remaining candidates are not consumed.
- DONE (exactly one cycle):
  - `done`=1; `match` is registered from the final `min_d` and stored threshold, so it is valid in the same cycle as `done`.
  - `d_ready`=0. Next state is IDLE.
- Latency: `done` is asserted in the cycle after the edge that accepted the last beat.
- Results (`min_d`, `min_idx`, `match`) hold in IDLE until the next accepted `start`.
- `start` in SCAN or DONE is ignored; it is not queued.
- Values of `d` > N are compared as plain unsigned values; no saturation or error.
- K=1: the first accepted beat completes the search.
- No other way to abort a search besides reset.

Test Plan:
- Reset: hold rst=0 with `d_valid`=1 and `start`=1 -> `d_ready`=0, `busy`=0, `done`=0, `min_d`=0, `min_idx`=0, `match`=0. Release rst in mid-cycle -> block stays IDLE until `start` is sampled.
- Basic (N=8, K=4, thresh=3): start, then back-to-back beats 5, 3, 7, 3 -> `done` pulses 1 cycle after the 4th beat; `min_d`=3, `min_idx`=1 (tie keeps the earlier index), `match`=1, `busy` falls the cycle after `done`.
- No match (K=4, thresh=2): beats 8, 8, 8, 8 -> `min_d`=8, `min_idx`=0, `match`=0. Separately, beats 2, 9, 9, 9 with thresh=2 -> `match`=1 (boundary is equal).
- Throttled input: beats 6, 1, 4, 2 with 0-3 idle cycles between them -> same result as back-to-back (`min_d`=1, `min_idx`=1); `d_ready` stays 1 throughout SCAN; the counter advances only on accepted beats.
- Early exit (EARLY_EXIT=1, K=4): beats 4, 0 -> `done` after the 2nd beat, `min_d`=0, `min_idx`=1, `d_ready`=0 from the DONE cycle onward. With EARLY_EXIT=0 and the same beats plus 5, 6 -> `done` only after the 4th beat, same `min_d` and `min_idx`.
- Control corner: `start` pulsed during SCAN -> no effect on counter or result. rst=0 after 2 of 4 beats -> all outputs clear, no `done`. A following `start` plus 4 beats completes normally.
